// File: rtl/poly_pair_tx_pkg.sv
// Shared constants and FSM encoding for the polynomial-pair serial transmitter.
// Optional checksum beat is enabled by defining POLY_TX_CHECKSUM_EN.
package poly_pair_tx_pkg;

    localparam int P    = 1049089;
    localparam int N    = 256;
    localparam int LOGP = $clog2(P);
    localparam int LOGN = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/poly_pair_tx_mod_add_p.sv
// Combinational modular adder: sum = (a + b) mod P, assuming a, b < P.
// Used by the checksum accumulator when POLY_TX_CHECKSUM_EN is defined.
module mod_add_p
    import poly_pair_tx_pkg::*;
(
    input  logic [LOGP-1:0] a,
    input  logic [LOGP-1:0] b,
    output logic [LOGP-1:0] sum
);

    logic [LOGP:0] raw;

    // One conditional subtraction suffices since a + b < 2P.
    always_comb begin
        raw = {1'b0, a} + {1'b0, b};
        if (raw >= (LOGP+1)'(P)) begin
            sum = LOGP'(raw - (LOGP+1)'(P));
        end else begin
            sum = raw[LOGP-1:0];
        end
    end

endmodule

// File: rtl/poly_pair_tx.sv
// Buffered serial transmitter for a coefficient pair (c0, c1) of ring polynomials.
// Define POLY_TX_CHECKSUM_EN to append a (sum mod P) checksum beat after index N-1.
module poly_pair_tx
    import poly_pair_tx_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [LOGN-1:0] wr_addr,
    input  logic [LOGP-1:0] wr_c0,
    input  logic [LOGP-1:0] wr_c1,
    input  logic            send,
    output logic            busy,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic [LOGP-1:0] tx_c0,
    output logic [LOGP-1:0] tx_c1,
    output logic [LOGN-1:0] tx_idx,
    output logic            tx_last,
    output logic            done,
    output logic            err_range
);

    state_t          state;
    logic [LOGP-1:0] mem_c0 [N];
    logic [LOGP-1:0] mem_c1 [N];
    logic            wr_ok;
    logic            fire;
    logic [LOGN-1:0] idx_next;

    assign wr_ok    = (wr_c0 < LOGP'(P)) && (wr_c1 < LOGP'(P));
    assign fire     = tx_valid & tx_ready;
    assign idx_next = tx_idx + LOGN'(1);

`ifdef POLY_TX_CHECKSUM_EN
    logic [LOGP-1:0] acc_c0;
    logic [LOGP-1:0] acc_c1;
    logic [LOGP-1:0] sum_c0;
    logic [LOGP-1:0] sum_c1;
    logic            chk_phase;

    mod_add_p u_add_c0 (.a(acc_c0), .b(tx_c0), .sum(sum_c0));
    mod_add_p u_add_c1 (.a(acc_c1), .b(tx_c1), .sum(sum_c1));
`endif

    // Buffer has no reset; send takes priority over a simultaneous write.
    always_ff @(posedge clk) begin
        if (state == IDLE && wr_en && !send && wr_ok) begin
            mem_c0[wr_addr] <= wr_c0;
            mem_c1[wr_addr] <= wr_c1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            tx_valid  <= 1'b0;
            tx_last   <= 1'b0;
            done      <= 1'b0;
            err_range <= 1'b0;
            tx_c0     <= '0;
            tx_c1     <= '0;
            tx_idx    <= '0;
`ifdef POLY_TX_CHECKSUM_EN
            acc_c0    <= '0;
            acc_c1    <= '0;
            chk_phase <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (send) begin
                        state     <= SEND;
                        busy      <= 1'b1;
                        tx_valid  <= 1'b1;
                        tx_c0     <= mem_c0[0];
                        tx_c1     <= mem_c1[0];
                        tx_idx    <= '0;
                        tx_last   <= 1'b0;
                        err_range <= 1'b0;
`ifdef POLY_TX_CHECKSUM_EN
                        acc_c0    <= '0;
                        acc_c1    <= '0;
                        chk_phase <= 1'b0;
`endif
                    end else if (wr_en && !wr_ok) begin
                        err_range <= 1'b1;
                    end
                end
                SEND: begin
                    if (fire) begin
`ifdef POLY_TX_CHECKSUM_EN
                        if (chk_phase) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            tx_valid <= 1'b0;
                            tx_last  <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            acc_c0 <= sum_c0;
                            acc_c1 <= sum_c1;
                            // Beat N-1 is folded in combinationally so the checksum needs no bubble.
                            if (tx_idx == LOGN'(N-1)) begin
                                tx_c0     <= sum_c0;
                                tx_c1     <= sum_c1;
                                tx_idx    <= '0;
                                tx_last   <= 1'b1;
                                chk_phase <= 1'b1;
                            end else begin
                                tx_c0  <= mem_c0[idx_next];
                                tx_c1  <= mem_c1[idx_next];
                                tx_idx <= idx_next;
                            end
                        end
`else
                        if (tx_idx == LOGN'(N-1)) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            tx_valid <= 1'b0;
                            tx_last  <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            tx_c0   <= mem_c0[idx_next];
                            tx_c1   <= mem_c1[idx_next];
                            tx_idx  <= idx_next;
                            tx_last <= (idx_next == LOGN'(N-1));
                        end
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_pair_tx.sv
// Scoreboard testbench for poly_pair_tx: a reference buffer model queues expected beats,
// a negedge monitor pops and compares on every fired beat.
module tb_poly_pair_tx;
    import poly_pair_tx_pkg::*;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            wr_en = 1'b0;
    logic [LOGN-1:0] wr_addr = '0;
    logic [LOGP-1:0] wr_c0 = '0;
    logic [LOGP-1:0] wr_c1 = '0;
    logic            send = 1'b0;
    logic            busy;
    logic            tx_valid;
    logic            tx_ready = 1'b0;
    logic [LOGP-1:0] tx_c0;
    logic [LOGP-1:0] tx_c1;
    logic [LOGN-1:0] tx_idx;
    logic            tx_last;
    logic            done;
    logic            err_range;

    typedef struct packed {
        logic [LOGN-1:0] idx;
        logic [LOGP-1:0] c0;
        logic [LOGP-1:0] c1;
        logic            last;
    } beat_t;

    beat_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    int    m_c0[N];
    int    m_c1[N];
    bit    m_err = 1'b0;
    int    beats_seen = 0;
    bit    stream_done = 1'b0;
    bit    done_due = 1'b0;
    bit    held = 1'b0;
    beat_t held_beat;

    always #5 clk = ~clk;

    poly_pair_tx dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_c0(wr_c0), .wr_c1(wr_c1), .send(send), .busy(busy),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_c0(tx_c0), .tx_c1(tx_c1),
        .tx_idx(tx_idx), .tx_last(tx_last), .done(done), .err_range(err_range)
    );

    task automatic checkOutput(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares every fired beat against the scoreboard, checks hold-while-stalled and done timing.
    always @(negedge clk) begin
        beat_t cur;
        beat_t expb;
        if (!reset) begin
            held     = 1'b0;
            done_due = 1'b0;
        end else begin
            cur = '{idx: tx_idx, c0: tx_c0, c1: tx_c1, last: tx_last};
            checkOutput("done", longint'(done), longint'(done_due));
            if (done_due) stream_done = 1'b1;
            done_due = 1'b0;
            if (held) begin
                tests++;
                if (!tx_valid || cur != held_beat) begin
                    fails++;
                    $display("[TB] FAIL hold: got v=%0b idx=%0d c0=%0d c1=%0d last=%0b, expected v=1 idx=%0d c0=%0d c1=%0d last=%0b",
                             tx_valid, tx_idx, tx_c0, tx_c1, tx_last,
                             held_beat.idx, held_beat.c0, held_beat.c1, held_beat.last);
                end
            end
            if (tx_valid && tx_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL beat: got unexpected idx=%0d c0=%0d, expected no beat", tx_idx, tx_c0);
                end else begin
                    expb = exp_q.pop_front();
                    if (cur != expb) begin
                        fails++;
                        $display("[TB] FAIL beat: got idx=%0d c0=%0d c1=%0d last=%0b, expected idx=%0d c0=%0d c1=%0d last=%0b",
                                 tx_idx, tx_c0, tx_c1, tx_last, expb.idx, expb.c0, expb.c1, expb.last);
                    end
                    if (expb.last) done_due = 1'b1;
                end
                beats_seen++;
                held = 1'b0;
            end else if (tx_valid) begin
                held      = 1'b1;
                held_beat = cur;
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic writeWord(input int addr, input int c0, input int c1);
        wr_en   = 1'b1;
        wr_addr = LOGN'(addr);
        wr_c0   = LOGP'(c0);
        wr_c1   = LOGP'(c1);
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (c0 < P && c1 < P) begin
            m_c0[addr] = c0;
            m_c1[addr] = c1;
        end else begin
            m_err = 1'b1;
        end
        checkOutput("err_range", longint'(err_range), longint'(m_err));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, longint'(tx_valid), 0);
        checkOutput({tag, "_busy"}, longint'(busy), 0);
        checkOutput({tag, "_last"}, longint'(tx_last), 0);
        checkOutput({tag, "_done"}, longint'(done), 0);
        checkOutput({tag, "_err"}, longint'(err_range), 0);
        checkOutput({tag, "_c0"}, longint'(tx_c0), 0);
        checkOutput({tag, "_c1"}, longint'(tx_c1), 0);
        checkOutput({tag, "_idx"}, longint'(tx_idx), 0);
    endtask

    // Issues send, queues the model's expected stream and runs until done (or a reset point).
    task automatic applyStimulus(input bit bp, input bit noise, input bit collide, input int reset_at);
        longint s0 = 0;
        longint s1 = 0;
        beat_t  b;
        for (int i = 0; i < N; i++) begin
            b.idx  = LOGN'(i);
            b.c0   = LOGP'(m_c0[i]);
            b.c1   = LOGP'(m_c1[i]);
            b.last = 1'b0;
            s0 += m_c0[i];
            s1 += m_c1[i];
`ifndef POLY_TX_CHECKSUM_EN
            b.last = (i == N-1);
`endif
            exp_q.push_back(b);
        end
`ifdef POLY_TX_CHECKSUM_EN
        b.idx  = '0;
        b.c0   = LOGP'(s0 % P);
        b.c1   = LOGP'(s1 % P);
        b.last = 1'b1;
        exp_q.push_back(b);
`endif
        stream_done = 1'b0;
        beats_seen  = 0;
        send        = 1'b1;
        if (collide) begin
            wr_en   = 1'b1;
            wr_addr = '0;
            wr_c0   = LOGP'(7);
            wr_c1   = LOGP'(7);
        end
        @(posedge clk); #1;
        send  = 1'b0;
        wr_en = 1'b0;
        m_err = 1'b0;
        checkOutput("busy_after_send", longint'(busy), 1);
        checkOutput("first_valid", longint'(tx_valid), 1);
        checkOutput("first_idx", longint'(tx_idx), 0);
        checkOutput("err_cleared", longint'(err_range), 0);
        for (int cyc = 0; cyc < 4000 && !stream_done; cyc++) begin
            if (reset_at >= 0 && beats_seen >= reset_at) begin
                reset = 1'b0;
                #1;
                checkAllZero("async_reset");
                exp_q.delete();
                tx_ready = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    checkOutput("no_done_in_reset", longint'(done), 0);
                end
                #2 reset = 1'b1;
                @(posedge clk); #1;
                checkOutput("idle_after_reset", longint'(busy), 0);
                return;
            end
            tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noise && cyc < 50) begin
                send    = 1'($urandom_range(0, 1));
                wr_en   = 1'($urandom_range(0, 1));
                wr_addr = LOGN'($urandom);
                wr_c0   = LOGP'($urandom_range(0, P-1));
                wr_c1   = LOGP'($urandom_range(0, P-1));
            end else begin
                send  = 1'b0;
                wr_en = 1'b0;
            end
            @(posedge clk); #1;
        end
        send     = 1'b0;
        wr_en    = 1'b0;
        tx_ready = 1'b0;
        if (!stream_done) begin
            tests++;
            fails++;
            $display("[TB] FAIL stream_timeout: got %0d beats, expected completion with done", beats_seen);
        end
        checkOutput("queue_drained", longint'(exp_q.size()), 0);
        checkOutput("busy_after_done", longint'(busy), 0);
    endtask

    task automatic fillRandom();
        for (int i = 0; i < N; i++) begin
            writeWord(i, int'($urandom_range(0, P-1)), int'($urandom_range(0, P-1)));
        end
    endtask

    initial begin
        #2;
        checkAllZero("reset");
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < N; i++) writeWord(i, i, P - 1 - i);
        applyStimulus(1'b0, 1'b0, 1'b0, -1);

        fillRandom();
        applyStimulus(1'b1, 1'b0, 1'b0, -1);
        applyStimulus(1'b0, 1'b0, 1'b0, -1);

        writeWord(5, P, int'($urandom_range(0, P-1)));
        writeWord(9, int'($urandom_range(0, P-1)), P + 3);
        writeWord(6, 12345, 54321);
        applyStimulus(1'b1, 1'b0, 1'b0, -1);

        applyStimulus(1'b1, 1'b1, 1'b1, -1);

        applyStimulus(1'b1, 1'b0, 1'b0, 100);
        fillRandom();
        applyStimulus(1'b0, 1'b0, 1'b0, -1);

`ifdef POLY_TX_CHECKSUM_EN
        for (int i = 0; i < N; i++) writeWord(i, P - 1, P - 1);
        applyStimulus(1'b0, 1'b0, 1'b0, -1);
        applyStimulus(1'b1, 1'b0, 1'b0, -1);
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
